// File: rtl/bram_reader_pkg.sv
// Shared types and constants for the BRAM burst reader.
package bram_reader_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN
  } state_t;

  localparam int unsigned FIFO_DEPTH = 2;

endpackage

// File: rtl/bram_burst_reader_if.sv
// Command, BRAM read port and output stream of the burst reader.
interface bram_burst_reader_if #(
  parameter int unsigned WIDTH      = 64,
  parameter int unsigned ADDR_WIDTH = 10
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [ADDR_WIDTH:0]   cmd_len;
  logic                  mem_r_valid;
  logic [ADDR_WIDTH-1:0] mem_r_addr;
  logic [WIDTH-1:0]      mem_r_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [WIDTH-1:0]      out_data;
  logic                  out_last;

  modport master (
    input  cmd_valid, cmd_addr, cmd_len, mem_r_data, out_ready,
    output cmd_ready, mem_r_valid, mem_r_addr, out_valid, out_data, out_last
  );

  modport slave (
    output cmd_valid, cmd_addr, cmd_len, mem_r_data, out_ready,
    input  cmd_ready, mem_r_valid, mem_r_addr, out_valid, out_data, out_last
  );
endinterface

// File: rtl/skid_fifo2.sv
// Two-entry FIFO absorbing BRAM read latency against output backpressure.
module skid_fifo2
  import bram_reader_pkg::*;
#(
  parameter int unsigned DW = 65
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata,
  output logic [1:0]    count
);

  logic [DW-1:0] mem [FIFO_DEPTH];
  logic          rd_ptr;
  logic          wr_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  assign rdata = mem[rd_ptr];

  // Upstream credit accounting must never push into a full FIFO.
  assert property (@(posedge clk) disable iff (rst) !(push && count == 2'(FIFO_DEPTH)));

endmodule

// File: rtl/bram_burst_reader.sv
// Burst read client: issues BRAM reads under FIFO credit and streams words out.
module bram_burst_reader
  import bram_reader_pkg::*;
#(
  parameter int unsigned WIDTH      = 64,
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                clk,
  input  logic                rst,
  bram_burst_reader_if.master bus,
  output logic                busy,
  output logic                done
);

  state_t                state, state_nx;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH:0]   len_q;
  logic [ADDR_WIDTH:0]   issue_cnt;
  logic                  inflight;
  logic                  inflight_last;
  logic                  zero_done;
  logic [1:0]            fifo_count;
  logic [WIDTH:0]        fifo_head;
  logic                  accept;
  logic                  pop;
  logic                  credit;
  logic                  issue_last;

  assign accept     = (state == IDLE) && bus.cmd_valid;
  assign pop        = bus.out_valid && bus.out_ready;
  assign credit     = ({1'b0, fifo_count} + {2'b0, inflight} - {2'b0, pop}) < 3'(FIFO_DEPTH);
  assign issue_last = (issue_cnt == len_q - 1'b1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx        = state;
    bus.cmd_ready   = 1'b0;
    bus.mem_r_valid = 1'b0;
    done            = zero_done;
    case (state)
      IDLE: begin
        bus.cmd_ready = 1'b1;
        if (bus.cmd_valid && bus.cmd_len != '0) state_nx = ISSUE;
      end
      ISSUE: begin
        bus.mem_r_valid = credit;
        if (credit && issue_last) state_nx = DRAIN;
      end
      DRAIN: begin
        if (pop && fifo_head[WIDTH]) begin
          state_nx = IDLE;
          done     = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // The last flag is tagged at issue time and travels with the word,
  // which is equivalent to comparing a delivery count against len-1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q        <= '0;
      len_q         <= '0;
      issue_cnt     <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      zero_done     <= 1'b0;
    end else begin
      inflight  <= bus.mem_r_valid;
      zero_done <= accept && (bus.cmd_len == '0);
      if (bus.mem_r_valid) inflight_last <= issue_last;
      if (accept) begin
        addr_q    <= bus.cmd_addr;
        len_q     <= bus.cmd_len;
        issue_cnt <= '0;
      end else if (bus.mem_r_valid) begin
        addr_q    <= addr_q + 1'b1;
        issue_cnt <= issue_cnt + 1'b1;
      end
    end
  end

  skid_fifo2 #(.DW(WIDTH + 1)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (inflight),
    .pop   (pop),
    .wdata ({inflight_last, bus.mem_r_data}),
    .rdata (fifo_head),
    .count (fifo_count)
  );

  assign bus.mem_r_addr = addr_q;
  assign bus.out_valid  = (fifo_count != '0);
  assign bus.out_data   = fifo_head[WIDTH-1:0];
  assign bus.out_last   = bus.out_valid && fifo_head[WIDTH];
  assign busy           = (state != IDLE);

endmodule

// File: tb/tb_bram_burst_reader.sv
// Scoreboard bench for bram_burst_reader with a behavioural BRAM.
module tb_bram_burst_reader;

  localparam int unsigned WIDTH = 64;
  localparam int unsigned AW    = 10;
  localparam int unsigned SIZE  = 1 << AW;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic busy, done;

  bram_burst_reader_if #(.WIDTH(WIDTH), .ADDR_WIDTH(AW)) bus ();

  bram_burst_reader #(.WIDTH(WIDTH), .ADDR_WIDTH(AW)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy),
    .done (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [WIDTH-1:0] ram [SIZE];
  always @(posedge clk) if (bus.mem_r_valid) bus.mem_r_data <= ram[bus.mem_r_addr];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [WIDTH:0] got, input logic [WIDTH:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  logic [WIDTH:0]  exp_q[$];
  logic [AW-1:0]   exp_rd_q[$];

  function automatic void push_exp(input logic [AW-1:0] a, input logic [AW:0] n);
    logic [AW-1:0] ad;
    for (int unsigned i = 0; i < n; i++) begin
      ad = a + AW'(i);
      exp_rd_q.push_back(ad);
      exp_q.push_back({(i == n - 1), ram[ad]});
    end
  endfunction

  // Monitor: reads and stream words are checked against the queues.
  int n_pop = 0, n_rd = 0, n_ov = 0, n_done = 0, occ = 0;
  int done_cyc = -1, first_rd_cyc = -1, first_ov_cyc = -1;
  logic           stall_prev = 1'b0;
  logic [WIDTH:0] stall_word;

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.mem_r_valid) begin
        n_rd++;
        occ++;
        if (first_rd_cyc < 0) first_rd_cyc = cyc;
        if (exp_rd_q.size() == 0) check("rd_extra", 65'(exp_rd_q.size()), 65'd1);
        else check("rd_addr", 65'(bus.mem_r_addr), 65'(exp_rd_q.pop_front()));
      end
      if (bus.out_valid) begin
        n_ov++;
        if (first_ov_cyc < 0) first_ov_cyc = cyc;
      end
      if (stall_prev) begin
        check("hold_valid", 65'(bus.out_valid), 65'd1);
        check("hold_word", {bus.out_last, bus.out_data}, stall_word);
      end
      stall_prev = bus.out_valid && !bus.out_ready;
      stall_word = {bus.out_last, bus.out_data};
      if (bus.out_valid && bus.out_ready) begin
        n_pop++;
        occ--;
        if (exp_q.size() == 0) check("out_extra", 65'(exp_q.size()), 65'd1);
        else check("out_word", {bus.out_last, bus.out_data}, exp_q.pop_front());
      end
      if (bus.mem_r_valid) check("credit_occ_le2", 65'(occ <= 2), 65'd1);
      if (done) begin
        n_done++;
        done_cyc = cyc;
      end
    end else begin
      stall_prev = 1'b0;
      occ        = 0;
    end
  end

  int rdy_mode = 0;
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        1:       bus.out_ready = (cyc % 3 == 0);
        2:       bus.out_ready = 1'($urandom_range(0, 1));
        default: bus.out_ready = 1'b1;
      endcase
    end
  end

  task automatic send(input logic [AW-1:0] a, input logic [AW:0] n, output int t);
    @(negedge clk);
    for (int i = 0; i < 3000 && !bus.cmd_ready; i++) @(negedge clk);
    check("cmd_ready_wait", 65'(bus.cmd_ready), 65'd1);
    bus.cmd_valid = 1'b1;
    bus.cmd_addr  = a;
    bus.cmd_len   = n;
    t             = cyc;
    first_rd_cyc  = -1;
    first_ov_cyc  = -1;
    push_exp(a, n);
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!busy && exp_q.size() == 0) break;
    end
    check(tag, 65'(!busy && exp_q.size() == 0), 65'd1);
    check("reads_all_issued", 65'(exp_rd_q.size()), 65'd0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_cmd_ready"}, 65'(bus.cmd_ready), 65'd1);
    check({tag, "_mem_r_valid"}, 65'(bus.mem_r_valid), 65'd0);
    check({tag, "_mem_r_addr"}, 65'(bus.mem_r_addr), 65'd0);
    check({tag, "_out_valid"}, 65'(bus.out_valid), 65'd0);
    check({tag, "_out_data"}, 65'(bus.out_data), 65'd0);
    check({tag, "_out_last"}, 65'(bus.out_last), 65'd0);
    check({tag, "_busy"}, 65'(busy), 65'd0);
    check({tag, "_done"}, 65'(done), 65'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int t, nrd0, nov0, d0, p0;
    for (int unsigned i = 0; i < SIZE; i++)
      ram[i] = {32'(i) * 32'h9E37_79B1, 32'hBEEF_0000 | 32'(i)};
    bus.cmd_valid = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_len   = '0;
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst = 1'b0;

    // Basic burst: fixed cycle timing relative to acceptance.
    send(10'd5, 11'd4, t);
    repeat (6) @(negedge clk);
    check("t1_done_at_T6", 65'(done), 65'd1);
    check("t1_busy_at_T6", 65'(bus.cmd_ready), 65'd0);
    @(negedge clk);
    check("t1_ready_at_T7", 65'(bus.cmd_ready), 65'd1);
    check("t1_done_cyc", 65'(done_cyc), 65'(t + 6));
    check("t1_first_rd", 65'(first_rd_cyc), 65'(t + 1));
    check("t1_first_ov", 65'(first_ov_cyc), 65'(t + 3));
    wait_idle("t1_idle", 50);

    // Address wrap with random backpressure.
    rdy_mode = 2;
    send(10'd1022, 11'd4, t);
    wait_idle("wrap_idle", 200);

    // 1,0,0 backpressure pattern.
    rdy_mode = 1;
    send(10'd40, 11'd6, t);
    wait_idle("bp_idle", 200);
    rdy_mode = 0;

    // Zero-length command.
    nrd0 = n_rd;
    nov0 = n_ov;
    send(10'd77, 11'd0, t);
    @(negedge clk);
    check("len0_done", 65'(done), 65'd1);
    check("len0_ready", 65'(bus.cmd_ready), 65'd1);
    repeat (3) @(negedge clk);
    check("len0_ready_later", 65'(bus.cmd_ready), 65'd1);
    check("len0_no_reads", 65'(n_rd - nrd0), 65'd0);
    check("len0_no_words", 65'(n_ov - nov0), 65'd0);
    check("len0_done_cyc", 65'(done_cyc), 65'(t + 1));

    // Full-memory burst.
    nrd0 = n_rd;
    send(10'd0, 11'(SIZE), t);
    wait_idle("full_idle", 3000);
    check("full_read_count", 65'(n_rd - nrd0), 65'(SIZE));

    // Command presented while busy must wait for completion.
    send(10'd100, 11'd8, t);
    repeat (2) @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_addr  = 10'd300;
    bus.cmd_len   = 11'd3;
    d0 = n_done;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.cmd_ready) break;
    end
    check("busy_cmd_ready", 65'(bus.cmd_ready), 65'd1);
    check("busy_cmd_after_done", 65'(n_done - d0), 65'd1);
    push_exp(10'd300, 11'd3);
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    wait_idle("busy_idle", 100);

    // Asynchronous reset in the middle of a burst.
    p0 = n_pop;
    send(10'd200, 11'd8, t);
    for (int i = 0; i < 100 && (n_pop - p0) < 3; i++) @(negedge clk);
    check("rst_mid_words", 65'(n_pop - p0), 65'd3);
    #2 rst = 1'b1;
    #1 check_reset_values("rst_mid");
    exp_q.delete();
    exp_rd_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    p0 = n_pop;
    send(10'd0, 11'd2, t);
    wait_idle("post_rst_idle", 50);
    repeat (5) @(negedge clk);
    check("post_rst_words", 65'(n_pop - p0), 65'd2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
